// File: rtl/redux_mem_dump_ctrl.sv
// redux_mem_dump_ctrl: shares the single data-memory port between the CPU
// load/store path and a dump engine that streams an address range out over
// a valid/ready interface. The CPU has priority. A starvation counter forces
// one dump grant (and stalls the CPU for that cycle) after STARVE_MAX
// consecutive denied fetch cycles.
module redux_mem_dump_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              dump_start,
  input  logic [ADDR_W-1:0] dump_first,
  input  logic [ADDR_W-1:0] dump_last,
  output logic              dump_busy,
  output logic              dump_done,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0]      STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [ADDR_W:0] CNT_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] span;
  logic [3:0]        starve;
  logic              cpu_req;
  logic              force_grant;
  logic              dump_grant;

  // Saturating increment for the starvation counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    sat_inc = (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Range length minus one; modular so first>last wraps through address 0.
  assign span = dump_last - dump_first;

  // Status outputs decode the registered state only, so neither out_ready
  // nor dump_start has a combinational path to them.
  assign dump_busy = (state == FETCH) || (state == HOLD);
  assign dump_done = (state == DONE);
  assign out_valid = (state == HOLD);
  assign cpu_rdata = mem_rdata;

  // Port arbitration: CPU wins unless the dump has starved long enough.
  always_comb begin
    cpu_req     = cpu_re | cpu_we;
    force_grant = (state == FETCH) && (starve == STARVE_LIM);
    mem_addr    = cpu_addr;
    mem_we      = 1'b0;
    mem_wdata   = cpu_wdata;
    cpu_stall   = 1'b0;
    dump_grant  = 1'b0;
    if (cpu_req && !force_grant) begin
      // A simultaneous load+store is a store.
      mem_we = cpu_we;
    end else if (state == FETCH) begin
      mem_addr   = ptr;
      dump_grant = 1'b1;
      cpu_stall  = cpu_req;
    end
  end

  // Next-state logic for the dump sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (dump_start) state_nxt = FETCH;
      FETCH: if (dump_grant) state_nxt = HOLD;
      HOLD:  if (out_ready)  state_nxt = (remaining != '0) ? FETCH : DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Range pointer, word count and the captured output beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      remaining <= '0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dump_start) begin
            ptr       <= dump_first;
            remaining <= {1'b0, span} + CNT_ONE;
          end
        end
        FETCH: begin
          if (dump_grant) begin
            out_data  <= mem_rdata;
            out_addr  <= ptr;
            ptr       <= ptr + PTR_ONE;
            remaining <= remaining - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Starvation counter: counts denied fetch cycles, clears otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              starve <= '0;
    else if (state == FETCH && !dump_grant) starve <= sat_inc(starve);
    else                                  starve <= '0;
  end

endmodule

// File: tb/tb_redux_mem_dump_ctrl.sv
// Directed bench for redux_mem_dump_ctrl with a behavioural data memory
// preloaded with mem[i] = i + 10.
module tb_redux_mem_dump_ctrl;

  logic       clk;
  logic       rst;
  logic       cpu_re, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       cpu_stall;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;
  logic       dump_start;
  logic [7:0] dump_first, dump_last;
  logic       dump_busy, dump_done, out_valid, out_ready;
  logic [7:0] out_addr, out_data;

  int checks = 0;
  int errors = 0;
  int exp_done = 0;

  redux_mem_dump_ctrl #(.ADDR_W(8), .DATA_W(8), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .dump_start(dump_start), .dump_first(dump_first), .dump_last(dump_last),
    .dump_busy(dump_busy), .dump_done(dump_done),
    .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: combinational read, synchronous write.
  logic [7:0] mem [256];
  logic       preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i + 10);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  // Beat and done-pulse monitor.
  int         cyc = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  logic [7:0] bq_addr[$];
  logic [7:0] bq_data[$];
  int         bq_cyc[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && out_valid === 1'b1 && out_ready) begin
      bq_addr.push_back(out_addr);
      bq_data.push_back(out_data);
      bq_cyc.push_back(cyc);
    end
    if (!rst && dump_done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_beats();
    bq_addr.delete();
    bq_data.delete();
    bq_cyc.delete();
  endtask

  task automatic start_dump(input logic [7:0] f, input logic [7:0] l);
    @(posedge clk); #1;
    dump_first = f;
    dump_last  = l;
    dump_start = 1'b1;
    @(posedge clk); #1;
    dump_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_cnt < exp_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done_cnt, exp_done);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, out_valid, 1);
  endtask

  // Beats must be first, first+1, ... (mod 256) carrying preload data.
  task automatic check_beats(input string tag, input logic [7:0] first, input int n);
    int bad;
    bad = 0;
    chk({tag, "_count"}, bq_addr.size(), n);
    for (int k = 0; k < n && k < bq_addr.size(); k++) begin
      if (bq_addr[k] !== 8'(first + k) || bq_data[k] !== 8'(first + k + 10)) bad++;
    end
    chk({tag, "_seq"}, bad, 0);
  endtask

  initial begin
    logic [15:0] hist;
    int          badld;
    int          n;
    rst = 1'b0;
    preload = 1'b1;
    cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dump_start = 1'b0; dump_first = '0; dump_last = '0;
    out_ready = 1'b1;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 preload = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_busy", dump_busy, 0);
    chk("rst_done", dump_done, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_data", out_data, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic dump 3..6: one beat every 2 cycles, done 1 cycle after last
    clear_beats();
    exp_done++;
    start_dump(8'd3, 8'd6);
    wait_done("basic_done", 40);
    check_beats("basic", 8'd3, 4);
    chk("basic_d0", bq_data[0], 8'd13);
    chk("basic_d3", bq_data[3], 8'd16);
    chk("basic_gap1", bq_cyc[1] - bq_cyc[0], 2);
    chk("basic_gap2", bq_cyc[2] - bq_cyc[1], 2);
    chk("basic_gap3", bq_cyc[3] - bq_cyc[2], 2);
    chk("basic_done_lat", done_cyc - bq_cyc[3], 1);
    @(negedge clk);
    chk("basic_busy_after", dump_busy, 0);
    chk("basic_done_once", dump_done, 0);

    // Wrap 254..1
    clear_beats();
    exp_done++;
    start_dump(8'd254, 8'd1);
    wait_done("wrap_done", 40);
    check_beats("wrap", 8'd254, 4);
    chk("wrap_a2", bq_addr[2], 8'd0);
    chk("wrap_d1", bq_data[1], 8'd9);

    // Full range 0..255
    clear_beats();
    exp_done++;
    start_dump(8'd0, 8'd255);
    wait_done("full_done", 1200);
    check_beats("full", 8'd0, 256);

    // Backpressure: hold out_ready low for 5 cycles in HOLD
    out_ready = 1'b0;
    clear_beats();
    exp_done++;
    start_dump(8'd20, 8'd22);
    wait_valid("bp_valid", 20);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_addr", out_addr, 8'd20);
      chk("bp_hold_data", out_data, 8'd30);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_done("bp_done", 40);
    check_beats("bp", 8'd20, 3);

    // Starvation: CPU loads every cycle; dump forced on every 5th FETCH cycle
    cpu_addr = 8'd100;
    cpu_re   = 1'b1;
    clear_beats();
    exp_done++;
    hist  = '0;
    badld = 0;
    start_dump(8'd40, 8'd41);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      hist[k] = cpu_stall;
      if (!cpu_stall && cpu_rdata !== 8'd110) badld++;
    end
    chk("starve_stall_pattern", hist, 16'h0820);
    chk("starve_loads", badld, 0);
    wait_done("starve_done", 20);
    @(posedge clk); #1 cpu_re = 1'b0;
    check_beats("starve", 8'd40, 2);

    // Write hazard: CPU stores 0x7F to ptr during the first FETCH cycle
    clear_beats();
    exp_done++;
    start_dump(8'd60, 8'd60);
    cpu_we = 1'b1; cpu_addr = 8'd60; cpu_wdata = 8'h7F;
    @(negedge clk);
    chk("haz_stall", cpu_stall, 0);
    chk("haz_busy", dump_busy, 1);
    @(posedge clk); #1 cpu_we = 1'b0;
    wait_done("haz_done", 20);
    chk("haz_count", bq_addr.size(), 1);
    chk("haz_addr", bq_addr[0], 8'd60);
    chk("haz_data", bq_data[0], 8'h7F);

    // Reset mid-dump during HOLD: immediate clear, no done pulse
    out_ready = 1'b0;
    clear_beats();
    start_dump(8'd80, 8'd85);
    wait_valid("rstmid_valid", 20);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_valid0", out_valid, 0);
    chk("rstmid_busy0", dump_busy, 0);
    chk("rstmid_addr0", out_addr, 0);
    chk("rstmid_data0", out_data, 0);
    chk("rstmid_done0", dump_done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    n = 0;
    repeat (5) begin
      @(negedge clk);
      if (dump_done === 1'b1) n++;
    end
    chk("rstmid_no_done", done_cnt + n, exp_done);
    chk("rstmid_idle", dump_busy, 0);

    // Restart after reset; a second start while busy is ignored
    clear_beats();
    exp_done++;
    start_dump(8'd90, 8'd92);
    @(posedge clk); #1;
    dump_first = 8'd0; dump_last = 8'd255; dump_start = 1'b1;
    @(posedge clk); #1 dump_start = 1'b0;
    wait_done("restart_done", 40);
    check_beats("restart", 8'd90, 3);
    repeat (5) @(negedge clk);
    chk("restart_idle", dump_busy, 0);
    chk("restart_done_total", done_cnt, exp_done);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/redux_mem_dump_ctrl.md
Name: redux_mem_dump_ctrl

Overview:
- Controller that shares the single redux data-memory port between the CPU datapath and a dump engine.
- The dump engine streams a memory address range out over a valid/ready interface, for debug and for end-of-run memory dumps.
- The CPU has priority. A starvation counter guarantees dump progress by stalling the CPU for one cycle when the dump has waited too long.
- Sits between the redux core's load/store path and the data memory.

Parameters:
- ADDR_W, 8, data-memory address width (256 words).
- DATA_W, 8, data-memory word width.
- STARVE_MAX, 4, consecutive denied dump cycles before the dump is forced one grant (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_re  in  1  CPU load request.
- cpu_we  in  1  CPU store request.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_rdata  out  DATA_W  load data (combinational from mem_rdata).
- cpu_stall  out  1  CPU must hold its request this cycle.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data (combinational read).
- dump_start  in  1  start-dump pulse.
- dump_first  in  ADDR_W  first address of the range (sampled at start).
- dump_last  in  ADDR_W  last address of the range (sampled at start).
- dump_busy  out  1  dump in progress.
- dump_done  out  1  one-cycle pulse after the last word is accepted.
- out_valid  out  1  dump word available.
- out_addr  out  ADDR_W  address of the dump word.
- out_data  out  DATA_W  dump word.
- out_ready  in  1  sink accepts the word.

Behaviour:
- Reset (asynchronous):
  - FSM to IDLE; address and count registers to 0; starve counter to 0.
  - dump_busy, dump_done, out_valid, cpu_stall are 0; out_addr and out_data are 0.
  - Reset mid-dump abandons the dump silently, with no dump_done.
- FSM states:
  - IDLE: dump_start=1 latches ptr=dump_first, remaining=((dump_last-dump_first) mod 2^ADDR_W)+1, held in ADDR_W+1 bits; next state FETCH.
  - FETCH: dump_busy=1. Dump wants the port. When granted: out_data<=mem_rdata, out_addr<=ptr, out_valid<=1, ptr<=ptr+1 (wraps 255->0), remaining-=1; next state HOLD. When not granted: stay in FETCH.
  - HOLD: out_valid=1 with out_addr/out_data held stable. When out_ready=1, out_valid drops next cycle; go to FETCH if remaining!=0, otherwise DONE.
  - DONE: dump_done=1 for exactly one cycle, dump_busy=0; next state IDLE.
- Range rules:
  - first==last dumps 1 word.
  - first=0, last=255 dumps 256 words.
  - first>last wraps, e.g. first=250, last=2 dumps 9 words: 250..255, then 0..2.
- dump_start while not IDLE is ignored.
- Arbitration, evaluated each cycle, purely combinational on current state:
  - cpu_req = cpu_re|cpu_we.
  - force = (FETCH && starve==STARVE_MAX).
  - If cpu_req && !force: CPU owns the port. mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata, cpu_stall=0.
  - Else if FETCH: dump owns the port. mem_addr=ptr, mem_we=0, cpu_stall=cpu_req.
  - Else: mem_addr=cpu_addr, mem_we=0.
  - cpu_rdata=mem_rdata at all times; it is valid only when cpu_stall=0.
- Starve counter:
  - Increments (saturating) each FETCH cycle the dump is denied.
  - Clears when the dump is granted or when the FSM is not in FETCH.
- A CPU store to the address about to be fetched has priority. The dump reads the new value on its next grant.
- If cpu_re and cpu_we are both asserted, treat as a store.
- No combinational path from out_ready to out_valid.
- No combinational path from dump_start to any output.

Test Plan:
- Basic dump. Memory preloaded with mem[i]=i+10; dump_first=3, dump_last=6; out_ready=1, no CPU traffic.
  - Required: 4 beats (3,13),(6,16) in order, one beat every 2 cycles.
  - dump_done pulses once, 1 cycle after the last acceptance; dump_busy=0 after.
- Wrap and full range.
  - first=254, last=1 -> addresses 254,255,0,1.
  - first=0, last=255 -> exactly 256 beats, then dump_done.
- Backpressure. out_ready=0 for 5 cycles while in HOLD.
  - Required: out_valid stays 1 and out_addr/out_data are unchanged.
  - No address is skipped or duplicated after out_ready=1.
- Starvation, STARVE_MAX=4. CPU asserts cpu_re every cycle during a dump.
  - Required: the dump is granted on every 5th FETCH cycle, with cpu_stall=1 in exactly that cycle.
  - All other CPU loads return the correct data with cpu_stall=0.
- Write hazard. CPU stores 0x7F to the address ptr in the same cycle the dump is in FETCH.
  - Required: the CPU wins; the dumped word for that address is 0x7F.
- Reset mid-dump. Assert rst during HOLD.
  - Required: outputs return to 0 immediately with no dump_done.
  - A new dump_start after reset runs normally.
  - dump_start pulsed while busy is ignored: the beat count is unchanged.
